// File: rtl/led_sched.sv
// led_sched: round-robin owner of a 4-bit LED bank among three requesters, each grant held for at least SLOT ticks of a DIV-clk prescaler.
// Latency: gnt 1 clk after req seen in IDLE, led follows gnt (live pat) 1 clk later; grantee dropping req releases in 1 clk.
// Backpressure: none; requesters keep req high while they want the bank. Build option LED_SCHED_BLANK_EN inserts a DIV-clk blank on preemption.
module led_sched #(
    parameter int DIV  = 25,
    parameter int SLOT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [11:0] pat,
    output logic [2:0]  gnt,
    output logic [3:0]  led,
    output logic        busy
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(SLOT + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [SW-1:0] SLOT_MAX  = SW'(SLOT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [2:0] to_onehot(input logic [1:0] i);
        logic [2:0] oh;
        oh = 3'b100;
        if (i == 2'd0) oh = 3'b001;
        else if (i == 2'd1) oh = 3'b010;
        return oh;
    endfunction

    // Returns {found, index}: first set bit of r strictly after last, wrapping back to last itself.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = rr_next(last);
        c2 = rr_next(c1);
        if (|(r & to_onehot(c1))) return {1'b1, c1};
        if (|(r & to_onehot(c2))) return {1'b1, c2};
        if (|(r & to_onehot(last))) return {1'b1, last};
        return 3'b000;
    endfunction

    function automatic logic [3:0] pat_of(input logic [11:0] p, input logic [1:0] i);
        logic [3:0] v;
        v = p[11:8];
        if (i == 2'd0) v = p[3:0];
        else if (i == 2'd1) v = p[7:4];
        return v;
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [3:0]      led_q, led_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      own_q, own_d;
`ifdef LED_SCHED_BLANK_EN
    logic [PW-1:0]   blk_q, blk_d;
`endif

    logic            tick;
    logic [2:0]      pick_idle;
    logic [2:0]      pick_pre;

    assign tick      = (presc_q == PRESC_MAX);
    assign pick_idle = rr_pick(req, last_q);
    // Preemption candidates exclude the current owner so it cannot re-win its own slot.
    assign pick_pre  = rr_pick(req & ~gnt_q, own_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        led_d   = led_q;
        slot_d  = slot_q;
        last_d  = last_q;
        own_d   = own_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
`ifdef LED_SCHED_BLANK_EN
        blk_d   = blk_q;
`endif
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                led_d = '0;
                if (pick_idle[2]) begin
                    state_d = S_OWN;
                    own_d   = pick_idle[1:0];
                    last_d  = pick_idle[1:0];
                    gnt_d   = to_onehot(pick_idle[1:0]);
                    slot_d  = '0;
                end
            end
            S_OWN: begin
                led_d = pat_of(pat, own_q);
                if (tick && (slot_q != SLOT_MAX)) slot_d = slot_q + SW'(1);
                // Grantee release takes priority over any preemption in the same cycle.
                if (!(|(req & gnt_q))) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    led_d   = '0;
                    slot_d  = '0;
                end else if ((slot_q == SLOT_MAX) && pick_pre[2]) begin
`ifdef LED_SCHED_BLANK_EN
                    state_d = S_BLANK;
                    gnt_d   = '0;
                    led_d   = '0;
                    slot_d  = '0;
                    blk_d   = '0;
`else
                    own_d   = pick_pre[1:0];
                    last_d  = pick_pre[1:0];
                    gnt_d   = to_onehot(pick_pre[1:0]);
                    slot_d  = '0;
`endif
                end
            end
`ifdef LED_SCHED_BLANK_EN
            S_BLANK: begin
                gnt_d = '0;
                led_d = '0;
                blk_d = blk_q + PW'(1);
                // Re-arbitrate at the end of the gap in case the pending requester went away.
                if (blk_q == PRESC_MAX) begin
                    blk_d = '0;
                    if (pick_idle[2]) begin
                        state_d = S_OWN;
                        own_d   = pick_idle[1:0];
                        last_d  = pick_idle[1:0];
                        gnt_d   = to_onehot(pick_idle[1:0]);
                        slot_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            led_q   <= '0;
            presc_q <= '0;
            slot_q  <= '0;
            last_q  <= 2'd2;
            own_q   <= 2'd0;
`ifdef LED_SCHED_BLANK_EN
            blk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            led_q   <= led_d;
            presc_q <= presc_d;
            slot_q  <= slot_d;
            last_q  <= last_d;
            own_q   <= own_d;
`ifdef LED_SCHED_BLANK_EN
            blk_q   <= blk_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign led  = led_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_sched.sv
// Scoreboard bench for led_sched (DIV=4, SLOT=2): expected outputs queued as stimulus is driven, popped at each negedge sample.
module tb_led_sched;
    localparam int DIV  = 4;
    localparam int SLOT = 2;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [11:0] pat;
    logic [2:0]  gnt;
    logic [3:0]  led;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int inv_bad  = 0;

    typedef struct {
        logic [2:0] g;
        logic [3:0] l;
        logic       b;
    } exp_t;
    exp_t sb[$];

    led_sched #(.DIV(DIV), .SLOT(SLOT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .pat  (pat),
        .gnt  (gnt),
        .led  (led),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Structural invariants sampled every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ($countones(gnt) > 1) inv_bad++;
            if (gnt === 3'b000 && led !== 4'h0) inv_bad++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [2:0] g, input logic [3:0] l, input logic b);
        exp_t e;
        e.g = g;
        e.l = l;
        e.b = b;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        pat   = 12'h000;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
        checks++; if (led !== 4'h0) begin failures++; $display("FAIL reset_led: got %h expected 0", led); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL reset_idle: gnt=%b busy=%b expected 000/0", gnt, busy); end
    endtask

    task automatic test_first_grant();
        exp_t e;
        pat = 12'h00A;
        req = 3'b001;
        push_exp(3'b001, 4'h0, 1'b1);
        push_exp(3'b001, 4'hA, 1'b1);
        push_exp(3'b001, 4'h5, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (gnt !== e.g) begin failures++; $display("FAIL first_grant c%0d: gnt=%b expected %b", c, gnt, e.g); end
            checks++; if (led !== e.l) begin failures++; $display("FAIL first_led c%0d: led=%h expected %h", c, led, e.l); end
            checks++; if (busy !== e.b) begin failures++; $display("FAIL first_busy c%0d: busy=%b expected %b", c, busy, e.b); end
            if (c == 1) pat[3:0] = 4'h5;
        end
    endtask

    task automatic test_drop();
        exp_t e;
        repeat (3) @(negedge clk);
        req = 3'b000;
        push_exp(3'b000, 4'h0, 1'b0);
        push_exp(3'b100, 4'h0, 1'b1);
        push_exp(3'b100, 4'hC, 1'b1);
        push_exp(3'b000, 4'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (gnt !== e.g) begin failures++; $display("FAIL drop_gnt c%0d: gnt=%b expected %b", c, gnt, e.g); end
            checks++; if (led !== e.l) begin failures++; $display("FAIL drop_led c%0d: led=%h expected %h", c, led, e.l); end
            checks++; if (busy !== e.b) begin failures++; $display("FAIL drop_busy c%0d: busy=%b expected %b", c, busy, e.b); end
            if (c == 0) begin
                req = 3'b100;
                pat[11:8] = 4'hC;
            end
            if (c == 2) req = 3'b000;
        end
    endtask

    task automatic test_alternate();
        logic [2:0] gq[$];
        logic [2:0] prev_g;
        logic [2:0] exp_g;
        int run_len, gap_len, runs, led_bad, exp_gap;
`ifdef LED_SCHED_BLANK_EN
        exp_gap = DIV;
`else
        exp_gap = 0;
`endif
        pat = 12'h03A;
        req = 3'b011;
        gq.push_back(3'b001);
        gq.push_back(3'b010);
        gq.push_back(3'b001);
        gq.push_back(3'b010);
        gq.push_back(3'b001);
        prev_g = 3'b000; run_len = 0; gap_len = 0; runs = 0; led_bad = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (gnt !== prev_g) begin
                if (prev_g != 3'b000 && runs >= 2) begin
                    checks++;
                    if (run_len != SLOT * DIV) begin failures++; $display("FAIL alt_hold run%0d: held %0d clk expected %0d", runs, run_len, SLOT * DIV); end
                end
                if (gnt != 3'b000) begin
                    if (runs >= 1) begin
                        checks++;
                        if (gap_len != exp_gap) begin failures++; $display("FAIL alt_gap run%0d: gap %0d clk expected %0d", runs, gap_len, exp_gap); end
                    end
                    if (gq.size() > 0) begin
                        exp_g = gq.pop_front();
                        checks++;
                        if (gnt !== exp_g) begin failures++; $display("FAIL alt_order run%0d: gnt=%b expected %b", runs, gnt, exp_g); end
                    end
                    runs++;
                    run_len = 1;
                    gap_len = 0;
                end else begin
                    gap_len = 1;
                    run_len = 0;
                end
            end else if (gnt != 3'b000) begin
                run_len++;
            end else begin
                gap_len++;
            end
            if (gnt != 3'b000 && run_len >= 2 && led !== ((gnt == 3'b001) ? pat[3:0] : pat[7:4])) led_bad++;
            prev_g = gnt;
        end
        checks++; if (gq.size() != 0) begin failures++; $display("FAIL alt_timeout: %0d grants missing expected 0", gq.size()); end
        checks++; if (led_bad != 0) begin failures++; $display("FAIL alt_led: %0d bad led cycles expected 0", led_bad); end
        req = 3'b000;
        repeat (DIV + 3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL alt_release: busy=%b expected 0", busy); end
    endtask

    task automatic test_hold_single();
        exp_t e;
        int bad;
        int n;
        bad = 0;
        pat = 12'h0B7;
        req = 3'b010;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL hold_first: gnt=%b expected 010", gnt); end
            end else if (gnt !== 3'b010) begin
                bad++;
            end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL hold_const: %0d cycles off 010 expected 0", bad); end
        // Slot is saturated, so a new requester preempts at once.
        req = 3'b011;
`ifdef LED_SCHED_BLANK_EN
        for (int i = 0; i < DIV; i++) push_exp(3'b000, 4'h0, 1'b1);
        push_exp(3'b001, 4'h0, 1'b1);
`else
        push_exp(3'b001, 4'hB, 1'b1);
`endif
        push_exp(3'b001, 4'h7, 1'b1);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (gnt !== e.g) begin failures++; $display("FAIL preempt_gnt c%0d: gnt=%b expected %b", c, gnt, e.g); end
            checks++; if (led !== e.l) begin failures++; $display("FAIL preempt_led c%0d: led=%h expected %h", c, led, e.l); end
            checks++; if (busy !== e.b) begin failures++; $display("FAIL preempt_busy c%0d: busy=%b expected %b", c, busy, e.b); end
        end
        req = 3'b000;
        repeat (DIV + 3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        exp_t e;
        pat = 12'h00F;
        req = 3'b001;
        push_exp(3'b001, 4'h0, 1'b1);
        push_exp(3'b001, 4'hF, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (gnt !== e.g) begin failures++; $display("FAIL arst_pre_gnt c%0d: gnt=%b expected %b", c, gnt, e.g); end
            checks++; if (led !== e.l) begin failures++; $display("FAIL arst_pre_led c%0d: led=%h expected %h", c, led, e.l); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL arst_gnt: got %b expected 000", gnt); end
        checks++; if (led !== 4'h0) begin failures++; $display("FAIL arst_led: got %h expected 0", led); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b expected 0", busy); end
        pat = 12'h006;
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(3'b001, 4'h0, 1'b1);
        push_exp(3'b001, 4'h6, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (gnt !== e.g) begin failures++; $display("FAIL arst_post_gnt c%0d: gnt=%b expected %b", c, gnt, e.g); end
            checks++; if (led !== e.l) begin failures++; $display("FAIL arst_post_led c%0d: led=%h expected %h", c, led, e.l); end
        end
    endtask

    task automatic test_drop_wins();
        exp_t e;
        // Reset realigns the prescaler so slot saturation lands on a known cycle.
        rst_n = 1'b0;
        req   = 3'b100;
        pat   = 12'h3A5;
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(3'b100, 4'h0, 1'b1);
        for (int i = 2; i <= 8; i++) push_exp(3'b100, 4'h3, 1'b1);
        push_exp(3'b000, 4'h0, 1'b0);
        push_exp(3'b001, 4'h0, 1'b1);
        push_exp(3'b001, 4'h5, 1'b1);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (gnt !== e.g) begin failures++; $display("FAIL dropwin_gnt c%0d: gnt=%b expected %b", c, gnt, e.g); end
            checks++; if (led !== e.l) begin failures++; $display("FAIL dropwin_led c%0d: led=%h expected %h", c, led, e.l); end
            checks++; if (busy !== e.b) begin failures++; $display("FAIL dropwin_busy c%0d: busy=%b expected %b", c, busy, e.b); end
            if (c == 1) req = 3'b111;
            if (c == 8) req = 3'b011;
        end
        req = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_invariants();
        checks++;
        if (inv_bad != 0) begin failures++; $display("FAIL invariants: %0d violations expected 0", inv_bad); end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        pat   = 12'h000;
        test_reset();
        test_first_grant();
        test_drop();
        test_alternate();
        test_hold_single();
        test_async_reset();
        test_drop_wins();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_sched.md
LED_SCHED -- requirements
Module: led_sched

Interface
REQ-001 SHALL have parameter DIV, default 25: clk cycles per scheduler tick (>=2).
REQ-002 SHALL have parameter SLOT, default 4: minimum ticks a grantee holds the LEDs (>=1).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  3  per-requester LED-bank request; bit i = requester i.
REQ-006 SHALL have port pat  input  12  requester patterns packed; pat[4i+3:4i] = requester i.
REQ-007 SHALL have port gnt  output  3  one-hot grant, registered; all-zero when no owner.
REQ-008 SHALL have port led  output  4  registered LED drive.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL run a prescaler 0..DIV-1 that wraps, with tick high for the one cycle the count equals DIV-1.
REQ-011 SHALL implement FSM states IDLE, OWN, BLANK; the only reachable states.
REQ-012 IDLE: gnt=0, led=0; if any req bit is high, SHALL pick the next requester round-robin after last_owner (order 0->1->2->0) and enter OWN next cycle.
REQ-013 Grant latency: req high at cycle n in IDLE -> gnt one-hot at n+1; led = grantee pattern from n+2.
REQ-014 OWN: led SHALL register pat of grantee every cycle (live pattern updates, 1-cycle latency).
REQ-015 OWN: slot counter SHALL clear on entry, increment on tick, and saturate at SLOT.
REQ-016 OWN: if grantee's req drops, SHALL deassert gnt and led=0 next cycle and return to IDLE, regardless of slot count.
REQ-017 OWN: if slot count == SLOT and another req bit is high, SHALL preempt: rotate to next pending requester round-robin.
REQ-018 OWN: if slot count == SLOT and no other requester is pending, SHALL keep the grant indefinitely.
REQ-019 Simultaneous grantee-drop and preemption condition: drop SHALL win (return to IDLE).
REQ-020 last_owner SHALL update on every grant; round-robin SHALL skip non-requesting indices.
REQ-021 gnt SHALL never have more than one bit set; led SHALL be 0 whenever gnt==0.

Reset
REQ-022 rst_n low SHALL asynchronously force state=IDLE, gnt=0, led=0, busy=0, prescaler=0, slot=0, last_owner=2 (so requester 0 wins first).
REQ-023 Reset mid-grant SHALL drop the grant immediately; no pattern latched from before reset survives.
REQ-024 Release SHALL be synchronous: the first rising edge after rst_n high evaluates IDLE normally.

Configuration
REQ-025 Macro LED_SCHED_BLANK_EN defined: preemption SHALL pass through BLANK (gnt=0, led=0) for exactly one tick period (until next tick) before the new gnt asserts.
REQ-026 Macro LED_SCHED_BLANK_EN undefined: BLANK SHALL be unreachable; preemption SHALL switch gnt directly in one clk cycle, led following one cycle later.
REQ-027 Grantee-drop behaviour (REQ-016) SHALL be identical with or without the macro.

Verification (DIV=4, SLOT=2)
REQ-028 Reset release, req=3'b001, pat[3:0]=4'hA -> gnt=3'b001 one cycle later, led=4'hA the following cycle, busy=1.
REQ-029 req=3'b011 held -> gnt alternates 001,010,001... each held >=8 clk (2 ticks); blank gap of 4 clk only when LED_SCHED_BLANK_EN defined.
REQ-030 Grantee 0 drops req after 3 clk -> gnt=0, led=0 next cycle, IDLE; then req=3'b100 -> gnt=3'b100.
REQ-031 Only requester 1 requesting for 50 clk -> gnt=3'b010 stays constant, slot saturates at 2.
REQ-032 rst_n pulsed low mid-OWN with led=4'hF -> gnt=0, led=0 asynchronously, before next clk edge.
REQ-033 All three requesting, grantee 2 drops req at the tick where slot reaches SLOT -> IDLE first, then gnt=3'b001.
